// File: rtl/muldiv_sched.sv
// Multi-cycle multiply/divide scheduler owning the HI/LO registers.
// Results are computed at issue, held pending, and committed when the busy count expires.
module muldiv_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start_E,
  input  logic [1:0]  MDOp_E,
  input  logic [1:0]  HiLoWrite_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        MDUse_D,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;
  logic              pend_dz_q, pend_dz_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  // Issue-time arithmetic
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, div_n, div_d, quo, rem;
  logic        is_signed;
  logic [31:0] res_hi, res_lo;
  logic        res_dz;

  always_comb begin
    prod      = '0;
    res_hi    = '0;
    res_lo    = '0;
    is_signed = ~MDOp_E[0];
    res_dz    = 1'b0;
    a_mag     = A_E[31] ? (~A_E + 32'd1) : A_E;
    b_mag     = B_E[31] ? (~B_E + 32'd1) : B_E;
    div_n     = is_signed ? a_mag : A_E;
    div_d     = is_signed ? b_mag : B_E;
    // Substitute a harmless divisor on /0; the result is discarded anyway.
    if (div_d == 32'd0) div_d = 32'd1;
    quo       = div_n / div_d;
    rem       = div_n % div_d;
    case (MDOp_E)
      2'b00: begin
        prod = {{32{A_E[31]}}, A_E} * {{32{B_E[31]}}, B_E};
        {res_hi, res_lo} = prod;
      end
      2'b01: begin
        prod = {32'd0, A_E} * {32'd0, B_E};
        {res_hi, res_lo} = prod;
      end
      2'b10: begin
        res_dz = (B_E == 32'd0);
        res_lo = (A_E[31] ^ B_E[31]) ? (~quo + 32'd1) : quo;
        res_hi = A_E[31] ? (~rem + 32'd1) : rem;
      end
      default: begin
        res_dz = (B_E == 32'd0);
        res_lo = quo;
        res_hi = rem;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (Start_E) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_dz_d = res_dz;
          cnt_d     = MDOp_E[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          state_d   = StRun;
        end else if (HiLoWrite_E == 2'b01) begin
          hi_d = A_E;
        end else if (HiLoWrite_E == 2'b10) begin
          lo_d = A_E;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy     = (state_q == StRun);
  // Start_E term covers the issue cycle, before Busy has risen.
  assign Stall_MD = MDUse_D & (Busy | Start_E);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: directed cases plus random ops against a cycle-level arithmetic model.
module tb_muldiv_sched;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Start_E = 1'b0;
  logic [1:0]  MDOp_E = 2'b00;
  logic [1:0]  HiLoWrite_E = 2'b00;
  logic [31:0] A_E = '0;
  logic [31:0] B_E = '0;
  logic        MDUse_D = 1'b0;
  logic        Busy, Stall_MD;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;
  int busy_cnt  = 0;

  // Reference model state
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_dz = 1'b0;
  int          m_left = 0;

  muldiv_sched #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .CLK(CLK), .RESET(RESET), .Start_E(Start_E), .MDOp_E(MDOp_E),
    .HiLoWrite_E(HiLoWrite_E), .A_E(A_E), .B_E(B_E), .MDUse_D(MDUse_D),
    .Busy(Busy), .Stall_MD(Stall_MD), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one mult/div operation, from plain integer arithmetic.
  task automatic model_compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_dz = 1'b0;
    case (op)
      2'b00: begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; m_phi = p[63:32]; m_plo = p[31:0]; end
      2'b10: begin
        if (b == 0) m_dz = 1'b1;
        else begin
          q = sa / sb; r = sa % sb;
          m_plo = q[31:0]; m_phi = r[31:0];
        end
      end
      default: begin
        if (b == 0) m_dz = 1'b1;
        else begin m_plo = a / b; m_phi = a % b; end
      end
    endcase
  endtask

  // One clock: check the combinational stall, advance the model, then check registered outputs.
  task automatic tick();
    #1;
    chk("stall", {31'd0, Stall_MD},
        {31'd0, MDUse_D & ((m_left > 0) | Start_E)});
    if (Stall_MD === 1'b1) stall_cnt++;
    if (RESET) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_dz) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (Start_E) begin
      model_compute(MDOp_E, A_E, B_E);
      m_left = MDOp_E[1] ? DivN : MultN;
    end else if (HiLoWrite_E == 2'b01) m_hi = A_E;
    else if (HiLoWrite_E == 2'b10) m_lo = A_E;
    @(posedge CLK);
    #1;
    if (Busy === 1'b1) busy_cnt++;
    chk("busy", {31'd0, Busy}, {31'd0, m_left > 0});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start_E = 1'b1; MDOp_E = op; A_E = a; B_E = b;
    tick();
    Start_E = 1'b0;
    busy_cnt = 1;
    repeat ((op[1] ? DivN : MultN) - 1) tick();
    chk("busy_len", busy_cnt, op[1] ? DivN : MultN);
    tick();
  endtask

  task automatic move(input logic [1:0] which, input logic [31:0] a);
    HiLoWrite_E = which; A_E = a;
    tick();
    HiLoWrite_E = 2'b00;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);

    issue(2'b00, 32'hFFFFFFFD, 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFF1);
    issue(2'b01, 32'hFFFFFFFF, 32'd2);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);
    issue(2'b00, 32'hFFFFFFFF, 32'd2);
    chk("mults_hi", HI, 32'hFFFFFFFF);
    chk("mults_lo", LO, 32'hFFFFFFFE);

    // mflo waiting in D through issue and all busy cycles
    MDUse_D = 1'b1;
    stall_cnt = 0;
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    MDUse_D = 1'b0;
    chk("stall_len", stall_cnt, 11);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    issue(2'b11, 32'hFFFFFFF9, 32'd2);
    chk("divu_lo", LO, 32'h7FFFFFFC);
    chk("divu_hi", HI, 32'h00000001);

    move(2'b01, 32'h12345678);
    move(2'b10, 32'h9ABCDEF0);
    issue(2'b10, 32'h00000064, 32'd0);
    chk("dz_hi", HI, 32'h12345678);
    chk("dz_lo", LO, 32'h9ABCDEF0);
    move(2'b10, 32'h00000055);
    chk("mtlo_lo", LO, 32'h00000055);
    chk("mtlo_busy", {31'd0, Busy}, 32'd0);

    // Start_E beats a simultaneous move; a move while busy is ignored.
    HiLoWrite_E = 2'b01; Start_E = 1'b1; MDOp_E = 2'b01; A_E = 32'd7; B_E = 32'd9;
    tick();
    Start_E = 1'b0; HiLoWrite_E = 2'b10; A_E = 32'hDEADBEEF;
    tick();
    HiLoWrite_E = 2'b00;
    repeat (MultN) tick();
    chk("win_lo", LO, 32'd63);
    chk("win_hi", HI, 32'd0);

    // Reset during the 4th busy cycle of a divide
    Start_E = 1'b1; MDOp_E = 2'b10; A_E = 32'd100; B_E = 32'd7;
    tick();
    Start_E = 1'b0;
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (DivN) tick();
    issue(2'b00, 32'd2, 32'd3);
    chk("post_lo", LO, 32'd6);
    chk("post_hi", HI, 32'd0);

    // Signed divide overflow corner and random mix
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9)) ^ {32{b[31]}};
      MDUse_D = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) move(2'($urandom_range(1, 2)), a);
      else begin
        HiLoWrite_E = 2'($urandom_range(0, 2));
        Start_E = 1'b1; MDOp_E = op; A_E = a; B_E = b;
        tick();
        Start_E = 1'b0; HiLoWrite_E = 2'b00;
        repeat ((op[1] ? DivN : MultN) + $urandom_range(0, 2)) tick();
      end
    end
    MDUse_D = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
